tcam_rule_wr: RTL

Rule-update engine upstream of the `alram1x` match RAM in the FPGA TCAM. Takes one ternary rule write or delete request: rule index, pattern and don't-care mask. Sweeps every RAM address (every possible key chunk) with read-modify-write, setting or clearing that rule's bit in each row. After a sweep, each RAM row holds the match vector for its key value, one bit per rule, ready for the downstream lookup and priority-encode stages.

---
 rtl/tcam_pkg.sv | 39 +++
 rtl/tcam_row_merge.sv | 31 +++
 rtl/tcam_rule_wr.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tcam_pkg.sv
// tcam_pkg
// Shared definitions for the FPGA TCAM rule-update and lookup stages.
//   - tcam_state_e : state encoding of the rule-write engine
//   - TCAM_WID / TCAM_AWID / TCAM_RIDW : default rule count, key-chunk width
//     and rule-index width
//   - tcam_match   : ternary pattern/mask compare of one key chunk, shared
//     with the lookup stage so both sides agree on what "match" means
package tcam_pkg;

    // Default geometry: 10 rules, 2-bit key chunk (4 RAM rows), 4-bit rule index.
    localparam int TCAM_WID  = 10;
    localparam int TCAM_AWID = 2;
    localparam int TCAM_RIDW = 4;

    // Widest key chunk tcam_match accepts; narrower chunks are zero-extended
    // by the caller, which cannot change the result.
    localparam int TCAM_KEY_MAXW = 16;

    // Rule-write engine states. ST_INIT is only reachable when the clear
    // sweep after reset is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_FIN  = 3'd3,
        ST_INIT = 3'd4
    } tcam_state_e;

    // A key matches when it agrees with the pattern on every bit the mask
    // does not mark as don't-care (mask bit 1 = don't care).
    function automatic logic tcam_match(
        input logic [TCAM_KEY_MAXW-1:0] key,
        input logic [TCAM_KEY_MAXW-1:0] pat,
        input logic [TCAM_KEY_MAXW-1:0] msk
    );
        return ((key ^ pat) & ~msk) == '0;
    endfunction

endpackage

// File: rtl/tcam_row_merge.sv
// tcam_row_merge
// Combinational row update: copies a RAM row and replaces the bit that
// belongs to one rule.
//   rdo  in  WID  : row as read from the match RAM
//   rule in  RIDW : rule whose bit is replaced
//   nbit in  1    : new value for that bit
//   wdi  out WID  : row to write back
module tcam_row_merge
    import tcam_pkg::*;
#(
    parameter int WID  = TCAM_WID,
    parameter int RIDW = TCAM_RIDW
) (
    input  logic [WID-1:0]  rdo,
    input  logic [RIDW-1:0] rule,
    input  logic            nbit,
    output logic [WID-1:0]  wdi
);

    // Compare the rule index against every bit position instead of indexing
    // with it, so an out-of-range index simply leaves the row untouched.
    always_comb begin
        wdi = rdo;
        for (int i = 0; i < WID; i++) begin
            if (rule == RIDW'(i)) begin
                wdi[i] = nbit;
            end
        end
    end

endmodule

// File: rtl/tcam_rule_wr.sv
// tcam_rule_wr
// Rule-update engine in front of the TCAM match RAM. One request adds or
// deletes a ternary rule by sweeping every RAM row with read-modify-write and
// setting/clearing that rule's bit according to the pattern/mask compare.
//
// Optional feature: define TCAM_RULE_WR_INIT_EN to clear every RAM row with a
// write sweep after reset before the first request is accepted.
//
// Ports
//   clk      in  1    : clock, also clocks both RAM ports
//   rst      in  1    : synchronous active-high reset
//   req_vld  in  1    : request valid
//   req_rdy  out 1    : engine can accept a request
//   req_rule in  RIDW : rule index
//   req_pat  in  AWID : rule pattern
//   req_msk  in  AWID : don't-care mask, 1 = don't care
//   req_del  in  1    : 1 = delete the rule
//   busy     out 1    : sweep (or clear sweep) in progress
//   done     out 1    : one-cycle pulse at the end of a request
//   err      out 1    : pulses with done when the request is rejected
//   ra       out AWID : RAM read address
//   rdo      in  WID  : RAM read data, one cycle after ra
//   wa       out AWID : RAM write address
//   wdi      out WID  : RAM write data
//   we       out 1    : RAM write enable
module tcam_rule_wr
    import tcam_pkg::*;
#(
    parameter int WID  = TCAM_WID,
    parameter int AWID = TCAM_AWID,
    parameter int DEP  = 1 << AWID,
    parameter int RIDW = TCAM_RIDW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_vld,
    output logic            req_rdy,
    input  logic [RIDW-1:0] req_rule,
    input  logic [AWID-1:0] req_pat,
    input  logic [AWID-1:0] req_msk,
    input  logic            req_del,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [AWID-1:0] ra,
    input  logic [WID-1:0]  rdo,
    output logic [AWID-1:0] wa,
    output logic [WID-1:0]  wdi,
    output logic            we
);

    localparam logic [AWID-1:0] LAST_ROW = AWID'(DEP - 1);

    tcam_state_e     state;
    logic [AWID-1:0] cnt;
    logic [RIDW-1:0] lat_rule;
    logic [AWID-1:0] lat_pat;
    logic [AWID-1:0] lat_msk;
    logic            lat_del;

    logic            hit;
    logic            nbit;
    logic [WID-1:0]  merged;

    // Does the row currently being rewritten (key value == cnt) match the
    // latched rule? A delete forces the bit to zero regardless.
    assign hit  = tcam_match(TCAM_KEY_MAXW'(cnt), TCAM_KEY_MAXW'(lat_pat),
                             TCAM_KEY_MAXW'(lat_msk));
    assign nbit = hit & ~lat_del;

    tcam_row_merge #(
        .WID  (WID),
        .RIDW (RIDW)
    ) u_merge (
        .rdo  (rdo),
        .rule (lat_rule),
        .nbit (nbit),
        .wdi  (merged)
    );

    // RAM side is decoded purely from registered state plus rdo, so we never
    // depends combinationally on the request inputs. Both addresses follow
    // cnt: RD reads row cnt, the following WR writes the same row back.
    // During the clear sweep, busy gates we so nothing is written in the
    // cycle right after reset while the engine is still arming.
    always_comb begin
        ra  = cnt;
        wa  = cnt;
        we  = 1'b0;
        wdi = '0;
        case (state)
            ST_WR: begin
                we  = 1'b1;
                wdi = merged;
            end
`ifdef TCAM_RULE_WR_INIT_EN
            ST_INIT: begin
                we  = busy;
            end
`endif
            default: begin
                we  = 1'b0;
            end
        endcase
    end

    // Control FSM with registered status outputs. done/err default low each
    // cycle and are raised only on the transition into FIN, giving a single
    // cycle pulse. req_rdy is registered, so after reset it rises one cycle
    // later (or once the clear sweep has finished).
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef TCAM_RULE_WR_INIT_EN
            state    <= ST_INIT;
`else
            state    <= ST_IDLE;
`endif
            cnt      <= '0;
            req_rdy  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            lat_rule <= '0;
            lat_pat  <= '0;
            lat_msk  <= '0;
            lat_del  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_rdy <= 1'b1;
                    if (req_vld && req_rdy) begin
                        lat_rule <= req_rule;
                        lat_pat  <= req_pat;
                        lat_msk  <= req_msk;
                        lat_del  <= req_del;
                        cnt      <= '0;
                        req_rdy  <= 1'b0;
                        busy     <= 1'b1;
                        // A rule index with no bit in the row is rejected
                        // without touching the RAM.
                        if (32'(req_rule) >= WID) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_WR;
                end
                ST_WR: begin
                    if (cnt == LAST_ROW) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= ST_RD;
                    end
                end
                ST_FIN: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    req_rdy <= 1'b1;
                end
`ifdef TCAM_RULE_WR_INIT_EN
                ST_INIT: begin
                    // First INIT cycle only arms busy; rows are then cleared
                    // one per cycle.
                    if (!busy) begin
                        busy <= 1'b1;
                    end else if (cnt == LAST_ROW) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        req_rdy <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    req_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule
